keypad_debouncer: RTL and testbench

KEYPAD_DEBOUNCER -- requirements
Module: keypad_debouncer

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/key_synchronizer.sv | 33 +++
 rtl/keypad_debouncer.sv | 146 ++++++++++++++
 tb/tb_keypad_debouncer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key width, idle code, FSM state enum and sizing helper
package keypad_pkg;

  localparam int KEY_WIDTH = 4;
  localparam logic [KEY_WIDTH-1:0] KEY_NONE = 4'b0000;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE,
    WAIT_RELEASE
  } key_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_synchronizer.sv
// rtl/key_synchronizer.sv - 2-flop synchronizer, resets to all-ones (buttons released)
module key_synchronizer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;
  logic [WIDTH-1:0] stage1_d;
  logic [WIDTH-1:0] stage2_d;

  always_comb begin
    stage1_d = d_in;
    stage2_d = stage1_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage1_q <= '1;
      stage2_q <= '1;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign d_out = stage2_q;

endmodule

// File: rtl/keypad_debouncer.sv
// rtl/keypad_debouncer.sv - 4-key debouncer emitting one-hot press pulses for the digital lock
// Optional auto-repeat while a key is held: define KEY_AUTO_REPEAT_EN.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key_raw,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic                 multi_error
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  logic [KEY_WIDTH-1:0] sync_out;
  logic [KEY_WIDTH-1:0] p;
  logic                 p_onehot;

  key_synchronizer #(.WIDTH(KEY_WIDTH)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_in  (key_raw),
    .d_out (sync_out)
  );

  assign p        = ~sync_out;
  assign p_onehot = $onehot(p);

  key_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0] held_q, held_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 multi_q, multi_d;
`ifdef KEY_AUTO_REPEAT_EN
  logic                 rep_q, rep_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    key_d   = KEY_NONE;
    multi_d = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (p_onehot) begin
          held_d  = p;
          state_d = DEB_PRESS;
        end else if (p != KEY_NONE) begin
          multi_d = 1'b1;
          held_d  = KEY_NONE;
          state_d = WAIT_RELEASE;
        end
      end
      DEB_PRESS: begin
        if (p != held_q) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          key_d   = held_q;
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (p == KEY_NONE) begin
          state_d = DEB_RELEASE;
        end
`ifdef KEY_AUTO_REPEAT_EN
        else if (p == held_q) begin
          // first repeat waits the long delay, later ones use the period
          if (cnt_q == (rep_q ? PER_LAST : DLY_LAST)) begin
            key_d = held_q;
            cnt_d = '0;
            rep_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      DEB_RELEASE: begin
        if (p != KEY_NONE) begin
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (p == KEY_NONE) begin
          state_d = DEB_RELEASE;
        end
      end
      default: state_d = IDLE;
    endcase
    // every state change starts the shared counter afresh
    if (state_d != state_q) begin
      cnt_d = '0;
`ifdef KEY_AUTO_REPEAT_EN
      rep_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= KEY_NONE;
      key_q   <= KEY_NONE;
      multi_q <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      key_q   <= key_d;
      multi_q <= multi_d;
`ifdef KEY_AUTO_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign key         = key_q;
  assign multi_error = multi_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_debouncer.sv
// tb/tb_keypad_debouncer.sv - directed self-checking bench for keypad_debouncer
module tb_keypad_debouncer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_raw;
  logic [3:0] key;
  logic       busy;
  logic       multi_error;

  int total = 0;
  int bad   = 0;

  int         key_pulses   = 0;
  int         multi_pulses = 0;
  int         viol         = 0;
  logic [3:0] key_log[$];

  keypad_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_raw     (key_raw),
    .key         (key),
    .busy        (busy),
    .multi_error (multi_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset) begin
      if (key != 4'b0000) begin
        key_pulses++;
        key_log.push_back(key);
      end
      if (multi_error) multi_pulses++;
      if ($countones(key) > 1 || (key != 4'b0000 && multi_error)) viol++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int kbase, mbase, lbase;

  initial begin
    reset   = 1'b0;
    key_raw = 4'b1111;
    step(2);
    check("reset_key", key, 4'b0000);
    check("reset_busy", busy, 1'b0);
    check("reset_multi", multi_error, 1'b0);
    reset = 1'b1;
    step(2);

    // single press, 20 cycles, then release
    kbase   = key_pulses;
    key_raw = 4'b0111;
    step(2);
    check("t1_busy_edge2", busy, 1'b0);
    step(1);
    check("t1_busy_edge3", busy, 1'b1);
    check("t1_key_edge3", key, 4'b0000);
    step(3);
    check("t1_key_edge6", key, 4'b0000);
    step(1);
    check("t1_key_edge7", key, 4'b1000);
    step(1);
    check("t1_key_edge8", key, 4'b0000);
    step(12);
    check("t1_pulses", key_pulses - kbase, 1);
    key_raw = 4'b1111;
    step(6);
    check("t1_busy_rel6", busy, 1'b1);
    step(1);
    check("t1_busy_rel7", busy, 1'b0);
    step(3);

    // bounce: never stable long enough
    kbase = key_pulses;
    repeat (4) begin
      key_raw = 4'b1110;
      step(2);
      key_raw = 4'b1111;
      step(2);
    end
    step(5);
    check("t2_pulses", key_pulses - kbase, 0);
    check("t2_busy", busy, 1'b0);

    // multi-key rejection then a valid press
    kbase   = key_pulses;
    mbase   = multi_pulses;
    key_raw = 4'b1100;
    step(2);
    check("t3_multi_edge2", multi_error, 1'b0);
    step(1);
    check("t3_multi_edge3", multi_error, 1'b1);
    check("t3_busy_edge3", busy, 1'b1);
    step(1);
    check("t3_multi_edge4", multi_error, 1'b0);
    step(6);
    check("t3_busy_held", busy, 1'b1);
    key_raw = 4'b1111;
    step(10);
    check("t3_busy_rel", busy, 1'b0);
    check("t3_multi_cnt", multi_pulses - mbase, 1);
    check("t3_key_cnt", key_pulses - kbase, 0);
    key_raw = 4'b1011;
    step(6);
    check("t3_key_edge6", key, 4'b0000);
    step(1);
    check("t3_key_edge7", key, 4'b0100);
    step(5);
    key_raw = 4'b1111;
    step(10);
    check("t3_key_total", key_pulses - kbase, 1);

    // reset during DEB_PRESS, key kept held
    key_raw = 4'b1110;
    step(4);
    check("t4_busy_pre", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_key", key, 4'b0000);
    check("t4_rst_multi", multi_error, 1'b0);
    step(2);
    reset = 1'b1;
    kbase = key_pulses;
    step(6);
    check("t4_key_edge6", key, 4'b0000);
    step(1);
    check("t4_key_edge7", key, 4'b0001);
    step(8);
    check("t4_pulses", key_pulses - kbase, 1);
    key_raw = 4'b1111;
    step(10);

    // passcode entry sequence
    kbase = key_pulses;
    lbase = key_log.size();
    key_raw = 4'b0111; step(10); key_raw = 4'b1111; step(10);
    key_raw = 4'b1110; step(10); key_raw = 4'b1111; step(10);
    key_raw = 4'b1011; step(10); key_raw = 4'b1111; step(10);
    check("t5_pulses", key_pulses - kbase, 3);
    check("t5_first", (key_log.size() > lbase) ? key_log[lbase] : 4'hf, 4'b1000);
    check("t5_second", (key_log.size() > lbase + 1) ? key_log[lbase + 1] : 4'hf, 4'b0001);
    check("t5_third", (key_log.size() > lbase + 2) ? key_log[lbase + 2] : 4'hf, 4'b0100);

    // added key while pressed, and a short release bounce
    kbase   = key_pulses;
    mbase   = multi_pulses;
    key_raw = 4'b1110;
    step(10);
    key_raw = 4'b1100;
    step(10);
    check("t6_busy_added", busy, 1'b1);
    key_raw = 4'b1111;
    step(2);
    key_raw = 4'b1110;
    step(10);
    check("t6_busy_bounce", busy, 1'b1);
    check("t6_pulses", key_pulses - kbase, 1);
    check("t6_multi", multi_pulses - mbase, 0);
    key_raw = 4'b1111;
    step(10);
    check("t6_busy_rel", busy, 1'b0);

    // long hold: auto-repeat or single pulse
    kbase   = key_pulses;
    key_raw = 4'b1110;
`ifdef KEY_AUTO_REPEAT_EN
    step(16);
    check("t7_key_edge16", key, 4'b0000);
    step(1);
    check("t7_key_edge17", key, 4'b0001);
    step(2);
    check("t7_key_edge19", key, 4'b0000);
    step(1);
    check("t7_key_edge20", key, 4'b0001);
    step(10);
    check("t7_pulses", key_pulses - kbase, 6);
`else
    step(30);
    check("t7_pulses", key_pulses - kbase, 1);
`endif
    key_raw = 4'b1111;
    step(10);
    check("t7_busy_rel", busy, 1'b0);

    check("onehot_exclusive", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
